ins_cache_loader: RTL and testbench
===================================

Name: ins_cache_loader

Overview:
- Instruction cache stage directly downstream of the program counter.
- Holds one ISA_DEPTH-entry window of the program image and fetches that window from DDR.
- Consumes the PC's instruction address and returns the addressed instruction to the AP controller.
- Drives the PC's ins_cache_rdy, st_cur_ins_cache and load_times inputs, which pace PC advance.

Parameters:
ADDR_WIDTH_MEM, 16, width of the instruction address from the PC
ISA_DEPTH, 64, entries per cache window (power of two)
TOTAL_ISA_DEPTH, 128, total program length in instructions
DDR_ADDR_WIDTH, 28, DDR byte address width
ISA_WIDTH, 64, instruction width; one DDR word per instruction, 8-byte stride
ISA_BASE_ADDR, 0, DDR byte address of instruction 0

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
addr_ins  input  ADDR_WIDTH_MEM  instruction address from the PC
ins_out  output  ISA_WIDTH  instruction read at addr_ins
ins_out_valid  output  1  ins_out holds the instruction for the addr_ins of the previous cycle
ins_cache_rdy  output  1  window loaded, lookups served
st_cur_ins_cache  output  4  current FSM state code
load_times  output  10  number of the window currently resident, counting from 1 (block index + 1)
prog_end  output  1  sticky flag: addr_ins at or beyond TOTAL_ISA_DEPTH
ddr_rd_req  output  1  DDR read request
ddr_rd_addr  output  DDR_ADDR_WIDTH  DDR read byte address
ddr_rd_ack  input  1  request accepted
ddr_rd_data  input  ISA_WIDTH  read data
ddr_rd_data_valid  input  1  read data valid

Behaviour:
- Clock and reset
  - All state changes on the rising edge of clk.
  - rst is synchronous, active-high.
- Reset values
  - st_cur_ins_cache = START (4'd1).
  - load_times = 0.
  - ins_cache_rdy, ins_out_valid, ddr_rd_req and prog_end = 0.
  - ins_out and ddr_rd_addr = 0.
  - Reset mid-load aborts the burst; ddr_rd_data_valid pulses arriving after reset are ignored until LOAD_INS is re-entered.
- Storage: ISA_DEPTH x ISA_WIDTH array with synchronous write and synchronous read.
- State codes: START = 1, LOAD_INS = 2, SENT_INS = 3, PROG_END = 4.
- START
  - Lasts one cycle.
  - Sets block index blk = 0 and word counter wcnt = 0, then goes to LOAD_INS.
- LOAD_INS
  - ins_cache_rdy = 0.
  - Word fetch: ddr_rd_req = 1 with ddr_rd_addr = ISA_BASE_ADDR + (blk*ISA_DEPTH + wcnt)*8, zero-extended/truncated to DDR_ADDR_WIDTH.
  - req/addr are held until the cycle ddr_rd_ack = 1; req drops the following cycle.
  - Only one outstanding request at a time: the next request is issued only after ddr_rd_data_valid for the previous one.
  - On each ddr_rd_data_valid, write mem[wcnt] and increment wcnt.
  - After word ISA_DEPTH-1 is written:
    - load_times <= blk + 1, wcnt <= 0.
    - Next state SENT_INS.
    - ins_cache_rdy = 1 from the SENT_INS entry cycle.
  - Words beyond TOTAL_ISA_DEPTH inside the last window are still fetched.
- SENT_INS
  - Hit when (addr_ins / ISA_DEPTH) == load_times - 1.
  - On a hit, ins_out <= mem[addr_ins mod ISA_DEPTH] and ins_out_valid <= 1 (1-cycle latency).
  - Any other addr_ins is a miss:
    - ins_out_valid <= 0, ins_cache_rdy <= 0.
    - blk <= addr_ins / ISA_DEPTH, then LOAD_INS.
  - The normal boundary case addr_ins == ISA_DEPTH*load_times is a miss to the next window. The PC stalls at that address until reload completes.
  - Backward jumps, returns and interrupt vectors use the same miss path.
- Priority in SENT_INS: prog_end check over miss over hit.
  - addr_ins >= TOTAL_ISA_DEPTH -> PROG_END.
  - This includes the interrupt-region MSB-set address with no program there.
- PROG_END
  - ins_cache_rdy = 0, ins_out_valid = 0, prog_end = 1.
  - No DDR traffic.
  - Exit only via rst.
- Outputs are registered; no combinational path from addr_ins to ins_out.
- load_times is 10 bits; blk+1 is truncated to 10 bits.

Test Plan:
- Reset then DDR model acking every request after 2 cycles and returning data 3 cycles later, data = index*3:
  - exactly 64 requests at addresses 0x0, 0x8 … 0x1F8;
  - then st_cur_ins_cache = 3, load_times = 1, ins_cache_rdy = 1.
- In SENT_INS, drive addr_ins = 5:
  - next cycle ins_out = 15, ins_out_valid = 1.
- Drive addr_ins = 64 (boundary):
  - state 2, ins_cache_rdy = 0;
  - requests at 0x200..0x3F8;
  - then load_times = 2;
  - addr_ins = 70 returns index-70 data.
- From window 2, drive addr_ins = 3 (jump back):
  - reload of window 0;
  - load_times = 1;
  - ins_out = 9.
- Drive addr_ins = 16'h8000:
  - state 4, prog_end = 1, ins_cache_rdy = 0;
  - no ddr_rd_req for 20 cycles.
- Assert rst during word 30 of a load:
  - next cycle state 1, load_times = 0, ddr_rd_req = 0;
  - a stale ddr_rd_data_valid is ignored;
  - reload restarts at address 0x0.

Source files
------------

// File: rtl/ins_cache_loader.sv
// Instruction cache loader: keeps one ISA_DEPTH-entry window of the program image,
// refills it from DDR one word at a time and serves PC lookups with one-cycle latency.
module ins_cache_loader #(
    parameter int unsigned ADDR_WIDTH_MEM  = 16,
    parameter int unsigned ISA_DEPTH       = 64,
    parameter int unsigned TOTAL_ISA_DEPTH = 128,
    parameter int unsigned DDR_ADDR_WIDTH  = 28,
    parameter int unsigned ISA_WIDTH       = 64,
    parameter logic [63:0] ISA_BASE_ADDR   = 64'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
    output logic [ISA_WIDTH-1:0]      ins_out,
    output logic                      ins_out_valid,
    output logic                      ins_cache_rdy,
    output logic [3:0]                st_cur_ins_cache,
    output logic [9:0]                load_times,
    output logic                      prog_end,
    output logic                      ddr_rd_req,
    output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
    input  logic                      ddr_rd_ack,
    input  logic [ISA_WIDTH-1:0]      ddr_rd_data,
    input  logic                      ddr_rd_data_valid
);

    localparam int unsigned IDX_W = $clog2(ISA_DEPTH);
    localparam int unsigned BLK_W = ADDR_WIDTH_MEM - IDX_W;
    localparam int unsigned LT_W  = 10;

    typedef enum logic [3:0] {
        START    = 4'd1,
        LOAD_INS = 4'd2,
        SENT_INS = 4'd3,
        PROG_END = 4'd4
    } state_t;

    state_t                    state, state_nxt;
    logic [BLK_W-1:0]          blk, blk_nxt;
    logic [IDX_W-1:0]          wcnt, wcnt_nxt;
    logic                      wait_data, wait_data_nxt;
    logic                      req_nxt;
    logic [DDR_ADDR_WIDTH-1:0] addr_nxt;
    logic                      rdy_nxt;
    logic                      valid_nxt;
    logic [LT_W-1:0]           load_times_nxt;
    logic                      prog_end_nxt;

    logic                      mem_we_c;
    logic                      mem_re_c;
    logic [ADDR_WIDTH_MEM-1:0] word_idx_c;
    logic [DDR_ADDR_WIDTH-1:0] fetch_addr_c;
    logic [BLK_W-1:0]          addr_blk_c;
    logic                      hit_c;
    logic                      past_end_c;

    logic [ISA_WIDTH-1:0] mem [ISA_DEPTH];

    assign st_cur_ins_cache = state;

    // Address decode for the fetch engine and the lookup path
    assign word_idx_c   = {blk, wcnt};
    assign fetch_addr_c = DDR_ADDR_WIDTH'(ISA_BASE_ADDR + 64'({word_idx_c, 3'b000}));
    assign addr_blk_c   = addr_ins[ADDR_WIDTH_MEM-1:IDX_W];
    assign hit_c        = 32'(addr_blk_c) == 32'(load_times - LT_W'(1));
    assign past_end_c   = 32'(addr_ins) >= TOTAL_ISA_DEPTH;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= START;
            blk           <= '0;
            wcnt          <= '0;
            wait_data     <= 1'b0;
            ddr_rd_req    <= 1'b0;
            ddr_rd_addr   <= '0;
            ins_cache_rdy <= 1'b0;
            ins_out_valid <= 1'b0;
            load_times    <= '0;
            prog_end      <= 1'b0;
        end else begin
            state         <= state_nxt;
            blk           <= blk_nxt;
            wcnt          <= wcnt_nxt;
            wait_data     <= wait_data_nxt;
            ddr_rd_req    <= req_nxt;
            ddr_rd_addr   <= addr_nxt;
            ins_cache_rdy <= rdy_nxt;
            ins_out_valid <= valid_nxt;
            load_times    <= load_times_nxt;
            prog_end      <= prog_end_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        blk_nxt        = blk;
        wcnt_nxt       = wcnt;
        wait_data_nxt  = wait_data;
        req_nxt        = ddr_rd_req;
        addr_nxt       = ddr_rd_addr;
        rdy_nxt        = ins_cache_rdy;
        valid_nxt      = ins_out_valid;
        load_times_nxt = load_times;
        prog_end_nxt   = prog_end;
        mem_we_c       = 1'b0;
        mem_re_c       = 1'b0;

        case (state)
            START: begin
                blk_nxt       = '0;
                wcnt_nxt      = '0;
                wait_data_nxt = 1'b0;
                req_nxt       = 1'b0;
                rdy_nxt       = 1'b0;
                valid_nxt     = 1'b0;
                state_nxt     = LOAD_INS;
            end

            // One outstanding request: issue, hold until ack, then wait for its data
            LOAD_INS: begin
                rdy_nxt   = 1'b0;
                valid_nxt = 1'b0;
                if (ddr_rd_req) begin
                    if (ddr_rd_ack) begin
                        req_nxt       = 1'b0;
                        wait_data_nxt = 1'b1;
                    end
                end else if (wait_data) begin
                    if (ddr_rd_data_valid) begin
                        mem_we_c      = 1'b1;
                        wait_data_nxt = 1'b0;
                        if (wcnt == IDX_W'(ISA_DEPTH - 1)) begin
                            wcnt_nxt       = '0;
                            load_times_nxt = LT_W'(32'(blk) + 32'd1);
                            rdy_nxt        = 1'b1;
                            state_nxt      = SENT_INS;
                        end else begin
                            wcnt_nxt = wcnt + IDX_W'(1);
                        end
                    end
                end else begin
                    req_nxt  = 1'b1;
                    addr_nxt = fetch_addr_c;
                end
            end

            // End of program outranks a miss, a miss outranks a hit
            SENT_INS: begin
                if (past_end_c) begin
                    prog_end_nxt = 1'b1;
                    rdy_nxt      = 1'b0;
                    valid_nxt    = 1'b0;
                    state_nxt    = PROG_END;
                end else if (!hit_c) begin
                    rdy_nxt   = 1'b0;
                    valid_nxt = 1'b0;
                    blk_nxt   = addr_blk_c;
                    wcnt_nxt  = '0;
                    state_nxt = LOAD_INS;
                end else begin
                    mem_re_c  = 1'b1;
                    valid_nxt = 1'b1;
                end
            end

            PROG_END: begin
                prog_end_nxt = 1'b1;
                rdy_nxt      = 1'b0;
                valid_nxt    = 1'b0;
                req_nxt      = 1'b0;
            end

            default: begin
                state_nxt = START;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we_c && !rst) begin
            mem[wcnt] <= ddr_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ins_out <= '0;
        end else if (mem_re_c) begin
            ins_out <= mem[addr_ins[IDX_W-1:0]];
        end
    end

endmodule

// File: tb/tb_ins_cache_loader.sv
// Directed bench for ins_cache_loader: window loads, hits, boundary and backward
// misses, end-of-program and reset in the middle of a burst.
module tb_ins_cache_loader;

    localparam int unsigned AW  = 16;
    localparam int unsigned DAW = 28;
    localparam int unsigned IW  = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [AW-1:0]  addr_ins;
    logic [IW-1:0]  ins_out;
    logic           ins_out_valid;
    logic           ins_cache_rdy;
    logic [3:0]     st_cur_ins_cache;
    logic [9:0]     load_times;
    logic           prog_end;
    logic           ddr_rd_req;
    logic [DAW-1:0] ddr_rd_addr;
    logic           ddr_rd_ack;
    logic [IW-1:0]  ddr_rd_data;
    logic           ddr_rd_data_valid;

    int n_assert = 0;
    int n_fail   = 0;
    logic [DAW-1:0] req_q[$];

    always #5 clk = ~clk;

    ins_cache_loader dut (
        .clk               (clk),
        .rst               (rst),
        .addr_ins          (addr_ins),
        .ins_out           (ins_out),
        .ins_out_valid     (ins_out_valid),
        .ins_cache_rdy     (ins_cache_rdy),
        .st_cur_ins_cache  (st_cur_ins_cache),
        .load_times        (load_times),
        .prog_end          (prog_end),
        .ddr_rd_req        (ddr_rd_req),
        .ddr_rd_addr       (ddr_rd_addr),
        .ddr_rd_ack        (ddr_rd_ack),
        .ddr_rd_data       (ddr_rd_data),
        .ddr_rd_data_valid (ddr_rd_data_valid)
    );

    // DDR model: ack two cycles after the request, data three cycles after the ack
    initial begin : ddr_model
        logic [DAW-1:0] a;
        ddr_rd_ack        = 1'b0;
        ddr_rd_data       = '0;
        ddr_rd_data_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (ddr_rd_req === 1'b1) begin
                a = ddr_rd_addr;
                req_q.push_back(a);
                @(negedge clk);
                ddr_rd_ack = 1'b1;
                @(negedge clk);
                ddr_rd_ack = 1'b0;
                repeat (2) @(negedge clk);
                ddr_rd_data       = 64'(a >> 3) * 64'd3;
                ddr_rd_data_valid = 1'b1;
                @(negedge clk);
                ddr_rd_data_valid = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_state(input logic [3:0] code, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (st_cur_ins_cache === code) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Number of logged requests that differ from a 64-word burst starting at base
    function automatic int seq_errors(input logic [DAW-1:0] base);
        int e = 0;
        if (req_q.size() != 64) e++;
        for (int i = 0; i < req_q.size() && i < 64; i++)
            if (req_q[i] !== base + DAW'(i * 8)) e++;
        return e;
    endfunction

    task automatic test_reset();
        rst      = 1'b1;
        addr_ins = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_assert++; if (st_cur_ins_cache !== 4'd1) begin n_fail++; $display("FAIL reset_state: got %0d expected 1", st_cur_ins_cache); end
        n_assert++; if (load_times !== 10'd0) begin n_fail++; $display("FAIL reset_load_times: got %0d expected 0", load_times); end
        n_assert++; if (ins_cache_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", ins_cache_rdy); end
        n_assert++; if (ins_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ins_out_valid); end
        n_assert++; if (ddr_rd_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", ddr_rd_req); end
        n_assert++; if (prog_end !== 1'b0) begin n_fail++; $display("FAIL reset_prog_end: got %b expected 0", prog_end); end
        n_assert++; if (ins_out !== 64'd0) begin n_fail++; $display("FAIL reset_ins_out: got %0h expected 0", ins_out); end
        n_assert++; if (ddr_rd_addr !== 28'd0) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", ddr_rd_addr); end
    endtask

    task automatic test_first_load();
        bit ok;
        req_q.delete();
        rst = 1'b0;
        @(negedge clk);
        n_assert++; if (st_cur_ins_cache !== 4'd2) begin n_fail++; $display("FAIL start_one_cycle: got %0d expected 2", st_cur_ins_cache); end
        wait_state(4'd3, 1500, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL load0_timeout: got state %0d expected 3", st_cur_ins_cache); end
        n_assert++; if (seq_errors(28'h0) !== 0) begin n_fail++; $display("FAIL load0_requests: got %0d reqs, %0d bad expected 64 reqs 0x0..0x1f8", req_q.size(), seq_errors(28'h0)); end
        n_assert++; if (load_times !== 10'd1) begin n_fail++; $display("FAIL load0_load_times: got %0d expected 1", load_times); end
        n_assert++; if (ins_cache_rdy !== 1'b1) begin n_fail++; $display("FAIL load0_rdy: got %b expected 1", ins_cache_rdy); end
    endtask

    task automatic test_hit();
        addr_ins = 16'd5;
        @(negedge clk);
        n_assert++; if (ins_out !== 64'd15) begin n_fail++; $display("FAIL hit5_data: got %0d expected 15", ins_out); end
        n_assert++; if (ins_out_valid !== 1'b1) begin n_fail++; $display("FAIL hit5_valid: got %b expected 1", ins_out_valid); end
        addr_ins = 16'd63;
        @(negedge clk);
        n_assert++; if (ins_out !== 64'd189) begin n_fail++; $display("FAIL hit63_data: got %0d expected 189", ins_out); end
    endtask

    task automatic test_boundary();
        bit ok;
        req_q.delete();
        addr_ins = 16'd64;
        @(negedge clk);
        n_assert++; if (st_cur_ins_cache !== 4'd2) begin n_fail++; $display("FAIL bnd_state: got %0d expected 2", st_cur_ins_cache); end
        n_assert++; if (ins_cache_rdy !== 1'b0) begin n_fail++; $display("FAIL bnd_rdy: got %b expected 0", ins_cache_rdy); end
        wait_state(4'd3, 1500, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL load1_timeout: got state %0d expected 3", st_cur_ins_cache); end
        n_assert++; if (seq_errors(28'h200) !== 0) begin n_fail++; $display("FAIL load1_requests: got %0d reqs, %0d bad expected 64 reqs 0x200..0x3f8", req_q.size(), seq_errors(28'h200)); end
        n_assert++; if (load_times !== 10'd2) begin n_fail++; $display("FAIL load1_load_times: got %0d expected 2", load_times); end
        addr_ins = 16'd70;
        @(negedge clk);
        n_assert++; if (ins_out !== 64'd210) begin n_fail++; $display("FAIL hit70_data: got %0d expected 210", ins_out); end
        n_assert++; if (ins_out_valid !== 1'b1) begin n_fail++; $display("FAIL hit70_valid: got %b expected 1", ins_out_valid); end
    endtask

    task automatic test_jump_back();
        bit ok;
        req_q.delete();
        addr_ins = 16'd3;
        @(negedge clk);
        n_assert++; if (st_cur_ins_cache !== 4'd2) begin n_fail++; $display("FAIL jmp_state: got %0d expected 2", st_cur_ins_cache); end
        n_assert++; if (ins_out_valid !== 1'b0) begin n_fail++; $display("FAIL jmp_valid: got %b expected 0", ins_out_valid); end
        wait_state(4'd3, 1500, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL reload0_timeout: got state %0d expected 3", st_cur_ins_cache); end
        n_assert++; if (seq_errors(28'h0) !== 0) begin n_fail++; $display("FAIL reload0_requests: got %0d reqs, %0d bad expected 64 reqs 0x0..0x1f8", req_q.size(), seq_errors(28'h0)); end
        n_assert++; if (load_times !== 10'd1) begin n_fail++; $display("FAIL reload0_load_times: got %0d expected 1", load_times); end
        @(negedge clk);
        n_assert++; if (ins_out !== 64'd9) begin n_fail++; $display("FAIL hit3_data: got %0d expected 9", ins_out); end
    endtask

    task automatic test_prog_end();
        int req_cycles = 0;
        addr_ins = 16'h8000;
        @(negedge clk);
        n_assert++; if (st_cur_ins_cache !== 4'd4) begin n_fail++; $display("FAIL pe_state: got %0d expected 4", st_cur_ins_cache); end
        n_assert++; if (prog_end !== 1'b1) begin n_fail++; $display("FAIL pe_flag: got %b expected 1", prog_end); end
        n_assert++; if (ins_cache_rdy !== 1'b0) begin n_fail++; $display("FAIL pe_rdy: got %b expected 0", ins_cache_rdy); end
        n_assert++; if (ins_out_valid !== 1'b0) begin n_fail++; $display("FAIL pe_valid: got %b expected 0", ins_out_valid); end
        addr_ins = 16'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ddr_rd_req !== 1'b0) req_cycles++;
        end
        n_assert++; if (req_cycles !== 0) begin n_fail++; $display("FAIL pe_no_ddr: got %0d req cycles expected 0", req_cycles); end
        n_assert++; if (st_cur_ins_cache !== 4'd4 || prog_end !== 1'b1) begin n_fail++; $display("FAIL pe_sticky: got state %0d flag %b expected 4 1", st_cur_ins_cache, prog_end); end
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        int polls = 0;
        addr_ins = 16'd0;
        rst = 1'b1;
        @(negedge clk);
        req_q.delete();
        rst = 1'b0;
        while (req_q.size() < 31 && polls < 1000) begin
            @(negedge clk);
            #2;
            polls++;
        end
        n_assert++; if (req_q.size() !== 31) begin n_fail++; $display("FAIL mid_reach_word30: got %0d reqs expected 31", req_q.size()); end
        rst = 1'b1;
        @(negedge clk);
        n_assert++; if (st_cur_ins_cache !== 4'd1) begin n_fail++; $display("FAIL mid_state: got %0d expected 1", st_cur_ins_cache); end
        n_assert++; if (load_times !== 10'd0) begin n_fail++; $display("FAIL mid_load_times: got %0d expected 0", load_times); end
        n_assert++; if (ddr_rd_req !== 1'b0) begin n_fail++; $display("FAIL mid_req: got %b expected 0", ddr_rd_req); end
        req_q.delete();
        rst = 1'b0;
        wait_state(4'd3, 1500, ok);
        n_assert++; if (!ok) begin n_fail++; $display("FAIL mid_reload_timeout: got state %0d expected 3", st_cur_ins_cache); end
        n_assert++; if (seq_errors(28'h0) !== 0) begin n_fail++; $display("FAIL mid_reload_requests: got %0d reqs, %0d bad expected 64 reqs 0x0..0x1f8", req_q.size(), seq_errors(28'h0)); end
        @(negedge clk);
        n_assert++; if (ins_out !== 64'd0) begin n_fail++; $display("FAIL mid_word0: got %0d expected 0", ins_out); end
        addr_ins = 16'd63;
        @(negedge clk);
        n_assert++; if (ins_out !== 64'd189) begin n_fail++; $display("FAIL mid_word63: got %0d expected 189", ins_out); end
        addr_ins = 16'd128;
        @(negedge clk);
        n_assert++; if (st_cur_ins_cache !== 4'd4) begin n_fail++; $display("FAIL end128_state: got %0d expected 4", st_cur_ins_cache); end
    endtask

    initial begin
        test_reset();
        test_first_load();
        test_hit();
        test_boundary();
        test_jump_back();
        test_prog_end();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
